// File: rtl/wall_clock_pkg.sv
// Shared wall-clock adjust definitions.
// Holds the adjust-mode FSM state encoding, the one-hot focus codes driven on
// adjust_mode (also used by adjust_inc_control and blinker), button indices
// and small decode helpers.
package wall_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HOURS   = 3'd2,
        ST_MINUTES = 3'd3,
        ST_SECONDS = 3'd4,
        ST_APPLY   = 3'd5
    } adj_state_t;

    localparam logic [2:0] ADJ_MODE_HOURS   = 3'b100;
    localparam logic [2:0] ADJ_MODE_MINUTES = 3'b010;
    localparam logic [2:0] ADJ_MODE_SECONDS = 3'b001;
    localparam logic [2:0] ADJ_MODE_NONE    = 3'b000;

    // Button lanes: one debouncer instance per lane.
    localparam int NUM_BTNS = 2;
    localparam int BTN_NEXT = 0;
    localparam int BTN_INC  = 1;

    function automatic logic is_edit_state(input adj_state_t s);
        return (s == ST_HOURS) || (s == ST_MINUTES) || (s == ST_SECONDS);
    endfunction

    function automatic logic [2:0] mode_of(input adj_state_t s);
        case (s)
            ST_HOURS:   return ADJ_MODE_HOURS;
            ST_MINUTES: return ADJ_MODE_MINUTES;
            ST_SECONDS: return ADJ_MODE_SECONDS;
            default:    return ADJ_MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Button conditioner: 2-flop synchronizer followed by a debounce counter.
// btn_level only changes once the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive clocks; any agreeing cycle restarts the
// count, so bounces shorter than that never reach the output.
// Ports:
//   clk       - clock
//   reset_n   - async active-low reset (flops and level clear to 0)
//   btn_raw   - raw asynchronous button input
//   btn_level - debounced level
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 10_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_ff1, sync_ff2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= btn_raw;
            sync_ff2 <= sync_ff1;
        end
    end

    // The cycle that would be the DEBOUNCE_CYCLES-th disagreement flips the
    // level directly, so the count never needs to exceed CNT_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (sync_ff2 == btn_level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt       <= '0;
            btn_level <= sync_ff2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adjust_mode_controller.sv
// Wall-clock adjust-mode controller.
// Debounces the "next" and "increment" buttons, walks the field focus
// IDLE -> LOAD -> HOURS -> MINUTES -> SECONDS -> APPLY -> IDLE on each
// "next" press, and cancels back to IDLE without applying after TIMEOUT_S
// seconds with no button activity.
// Ports:
//   clk                  - clock, CLK_RATE_HZ
//   reset_n              - async active-low reset
//   adjustment_next      - raw "next field" button
//   adjustment_increment - raw "increment" button
//   adjust_mode          - one-hot focus (100 h, 010 m, 001 s, 000 none)
//   select_adjust        - 1 while the display shows the adjust register
//   adjust_load          - 1-cycle pulse: running time -> adjust register
//   timer_load           - 1-cycle pulse: adjust register -> running time
//   increment_level      - debounced increment, only while editing a field
module adjust_mode_controller
    import wall_clock_pkg::*;
#(
    parameter int CLK_RATE_HZ     = 1_000_000,
    parameter int TIMEOUT_S       = 10,
    parameter int DEBOUNCE_CYCLES = 10_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adjustment_next,
    input  logic       adjustment_increment,
    output logic [2:0] adjust_mode,
    output logic       select_adjust,
    output logic       adjust_load,
    output logic       timer_load,
    output logic       increment_level
);

    localparam int unsigned TMO_LIMIT = TIMEOUT_S * CLK_RATE_HZ - 1;
    localparam int TMO_W = (TMO_LIMIT > 0) ? $clog2(TMO_LIMIT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_LIMIT);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_deb;
    logic                next_deb_q;
    logic                next_edge;
    logic                inc_deb;
    logic                timeout;
    logic [TMO_W-1:0]    tmo_cnt;

    adj_state_t state_q, state_d;

    logic [2:0] mode_d;
    logic       select_d, aload_d, tload_d;

    assign btn_raw[BTN_NEXT] = adjustment_next;
    assign btn_raw[BTN_INC]  = adjustment_increment;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk      (clk),
            .reset_n  (reset_n),
            .btn_raw  (btn_raw[b]),
            .btn_level(btn_deb[b])
        );
    end

    assign inc_deb = btn_deb[BTN_INC];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) next_deb_q <= 1'b0;
        else          next_deb_q <= btn_deb[BTN_NEXT];
    end

    assign next_edge = btn_deb[BTN_NEXT] & ~next_deb_q;

    // Inactivity counter: only runs while a field is being edited. Holding
    // increment keeps it at zero, so the timeout measures from the release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_LOAD || next_edge || inc_deb ||
                     !is_edit_state(state_q)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = is_edit_state(state_q) && (tmo_cnt == TMO_MAX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: next_edge is checked before timeout so a press landing on
    // the timeout cycle still advances (and can still apply).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (next_edge) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_HOURS;
            ST_HOURS:   if (next_edge) state_d = ST_MINUTES;
                        else if (timeout) state_d = ST_IDLE;
            ST_MINUTES: if (next_edge) state_d = ST_SECONDS;
                        else if (timeout) state_d = ST_IDLE;
            ST_SECONDS: if (next_edge) state_d = ST_APPLY;
                        else if (timeout) state_d = ST_IDLE;
            ST_APPLY:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state and registered below, so the
    // registered outputs line up with state_q in the same cycle.
    always_comb begin
        mode_d   = mode_of(state_d);
        select_d = (state_d != ST_IDLE);
        aload_d  = (state_d == ST_LOAD);
        tload_d  = (state_d == ST_APPLY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adjust_mode     <= ADJ_MODE_NONE;
            select_adjust   <= 1'b0;
            adjust_load     <= 1'b0;
            timer_load      <= 1'b0;
            increment_level <= 1'b0;
        end else begin
            adjust_mode     <= mode_d;
            select_adjust   <= select_d;
            adjust_load     <= aload_d;
            timer_load      <= tload_d;
            increment_level <= inc_deb & is_edit_state(state_q);
        end
    end

endmodule
